// File: rtl/comparador_serial_nibble.sv
// Serial multi-nibble magnitude comparator.
// Latches two unsigned operands and presents them one nibble pair per cycle,
// most significant nibble first, to an external combinational 4-bit comparator.
// It stops at the first unequal nibble and registers a full-width
// maior/menor/igual result, or erro if the comparator flags are not one-hot.
module comparador_serial_nibble #(
  parameter int N_NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [4*N_NIBBLES-1:0] a,
  input  logic [4*N_NIBBLES-1:0] b,
  output logic [3:0]             nib_a,
  output logic [3:0]             nib_b,
  input  logic                   cmp_maior,
  input  logic                   cmp_menor,
  input  logic                   cmp_igual,
  output logic                   busy,
  output logic                   done,
  output logic                   maior,
  output logic                   menor,
  output logic                   igual,
  output logic                   erro
);

  localparam int W     = 4 * N_NIBBLES;
  localparam int IDX_W = $clog2(N_NIBBLES);

  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(N_NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPARA = 2'd1,
    FIM     = 2'd2
  } state_t;

  // Exactly one of the three comparator flags must be set for a usable answer.
  function automatic logic f_flags_one_hot(input logic f_maior,
                                           input logic f_menor,
                                           input logic f_igual);
    logic [2:0] v;
    v = {f_maior, f_menor, f_igual};
    return (v == 3'b100) || (v == 3'b010) || (v == 3'b001);
  endfunction

  state_t           r_state;
  logic [W-1:0]     r_a;
  logic [W-1:0]     r_b;
  logic [IDX_W-1:0] r_idx;
  logic             r_maior;
  logic             r_menor;
  logic             r_igual;
  logic             r_erro;

  state_t           w_state_nx;
  logic [W-1:0]     w_a_nx;
  logic [W-1:0]     w_b_nx;
  logic [IDX_W-1:0] w_idx_nx;
  logic             w_maior_nx;
  logic             w_menor_nx;
  logic             w_igual_nx;
  logic             w_erro_nx;
  logic             w_one_hot;

  assign w_one_hot = f_flags_one_hot(cmp_maior, cmp_menor, cmp_igual);

  // State, operand, index and result registers; reset clears everything and aborts any run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_idx   <= '0;
      r_maior <= 1'b0;
      r_menor <= 1'b0;
      r_igual <= 1'b0;
      r_erro  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_a     <= w_a_nx;
      r_b     <= w_b_nx;
      r_idx   <= w_idx_nx;
      r_maior <= w_maior_nx;
      r_menor <= w_menor_nx;
      r_igual <= w_igual_nx;
      r_erro  <= w_erro_nx;
    end
  end

  // Next-state logic: accept start in IDLE, walk nibbles MSB-first, capture result on entry to FIM.
  always_comb begin
    w_state_nx = r_state;
    w_a_nx     = r_a;
    w_b_nx     = r_b;
    w_idx_nx   = r_idx;
    w_maior_nx = r_maior;
    w_menor_nx = r_menor;
    w_igual_nx = r_igual;
    w_erro_nx  = r_erro;

    case (r_state)
      IDLE: begin
        if (start) begin
          w_a_nx     = a;
          w_b_nx     = b;
          w_idx_nx   = IDX_TOP;
          w_state_nx = COMPARA;
        end
      end

      COMPARA: begin
        if (!w_one_hot) begin
          w_maior_nx = 1'b0;
          w_menor_nx = 1'b0;
          w_igual_nx = 1'b0;
          w_erro_nx  = 1'b1;
          w_state_nx = FIM;
        end else if (cmp_maior) begin
          w_maior_nx = 1'b1;
          w_menor_nx = 1'b0;
          w_igual_nx = 1'b0;
          w_erro_nx  = 1'b0;
          w_state_nx = FIM;
        end else if (cmp_menor) begin
          w_maior_nx = 1'b0;
          w_menor_nx = 1'b1;
          w_igual_nx = 1'b0;
          w_erro_nx  = 1'b0;
          w_state_nx = FIM;
        end else if (r_idx != '0) begin
          // Nibbles equal so far; the index stops at 0 so it never wraps.
          w_idx_nx = r_idx - 1'b1;
        end else begin
          w_maior_nx = 1'b0;
          w_menor_nx = 1'b0;
          w_igual_nx = 1'b1;
          w_erro_nx  = 1'b0;
          w_state_nx = FIM;
        end
      end

      FIM: begin
        w_state_nx = IDLE;
      end

      default: begin
        w_state_nx = IDLE;
      end
    endcase
  end

  // Nibble pair at the current index goes straight from the operand registers to the comparator.
  assign nib_a = r_a[{r_idx, 2'b00} +: 4];
  assign nib_b = r_b[{r_idx, 2'b00} +: 4];

  assign busy  = (r_state != IDLE);
  assign done  = (r_state == FIM);
  assign maior = r_maior;
  assign menor = r_menor;
  assign igual = r_igual;
  assign erro  = r_erro;

endmodule

// File: tb/tb_comparador_serial_nibble.sv
// Testbench for comparador_serial_nibble with N_NIBBLES=4.
// Models the external 4-bit comparator, with an override to inject bad flags.
module tb_comparador_serial_nibble;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic [3:0]  nib_a;
  logic [3:0]  nib_b;
  logic        cmp_maior;
  logic        cmp_menor;
  logic        cmp_igual;
  logic        busy;
  logic        done;
  logic        maior;
  logic        menor;
  logic        igual;
  logic        erro;

  logic        force_en;
  logic [2:0]  force_flags;

  int n_checks;
  int n_errors;

  comparador_serial_nibble #(.N_NIBBLES(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .a         (a),
    .b         (b),
    .nib_a     (nib_a),
    .nib_b     (nib_b),
    .cmp_maior (cmp_maior),
    .cmp_menor (cmp_menor),
    .cmp_igual (cmp_igual),
    .busy      (busy),
    .done      (done),
    .maior     (maior),
    .menor     (menor),
    .igual     (igual),
    .erro      (erro)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External comparator model, optionally overridden with forced flags.
  always_comb begin
    cmp_maior = (nib_a > nib_b);
    cmp_menor = (nib_a < nib_b);
    cmp_igual = (nib_a == nib_b);
    if (force_en) begin
      {cmp_maior, cmp_menor, cmp_igual} = force_flags;
    end
  end

  typedef struct {
    logic [15:0] va;
    logic [15:0] vb;
    int          lat;
    logic        e_maior;
    logic        e_menor;
    logic        e_igual;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Launch a comparison and wait (bounded) for done; returns cycle number of done.
  task automatic run_cmp(input logic [15:0] va, input logic [15:0] vb, output int cyc);
    @(negedge clk);
    a = va;
    b = vb;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (done !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int cyc;
    int ndone;
    logic [3:0] exp_na [4];
    logic [3:0] exp_nb [4];

    n_checks    = 0;
    n_errors    = 0;
    rst_n       = 1'b0;
    start       = 1'b0;
    a           = '0;
    b           = '0;
    force_en    = 1'b0;
    force_flags = 3'b000;

    vecs[0] = '{16'h9000, 16'h1FFF, 2, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{16'hABC3, 16'hABC7, 5, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{16'hFFFF, 16'hFFFF, 5, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{16'h0000, 16'h0000, 5, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{16'h1234, 16'h1334, 3, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{16'h5678, 16'h5668, 4, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{16'h0001, 16'h0000, 5, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{16'h0000, 16'hF000, 2, 1'b0, 1'b1, 1'b0};

    // Reset state
    #1;
    chk("rst_busy",  busy,  1'b0);
    chk("rst_done",  done,  1'b0);
    chk("rst_flags", {maior, menor, igual, erro}, 4'b0000);
    chk("rst_nib",   {nib_a, nib_b}, 8'h00);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_busy", busy, 1'b0);

    // Table-driven comparisons
    foreach (vecs[i]) begin
      run_cmp(vecs[i].va, vecs[i].vb, cyc);
      chk($sformatf("v%0d_latency", i), cyc, vecs[i].lat);
      chk($sformatf("v%0d_busy_at_done", i), busy, 1'b1);
      chk($sformatf("v%0d_result", i), {maior, menor, igual, erro},
          {vecs[i].e_maior, vecs[i].e_menor, vecs[i].e_igual, 1'b0});
      @(negedge clk);
      chk($sformatf("v%0d_done_pulse", i), {done, busy}, 2'b00);
      chk($sformatf("v%0d_held", i), {maior, menor, igual, erro},
          {vecs[i].e_maior, vecs[i].e_menor, vecs[i].e_igual, 1'b0});
    end

    // LSB decides: nibble trace A/A, B/B, C/C, 3/7 on cycles 1..4, done on 5
    exp_na = '{4'hA, 4'hB, 4'hC, 4'h3};
    exp_nb = '{4'hA, 4'hB, 4'hC, 4'h7};
    @(negedge clk);
    a = 16'hABC3;
    b = 16'hABC7;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("trace_c%0d_nib", i + 1), {nib_a, nib_b}, {exp_na[i], exp_nb[i]});
      chk($sformatf("trace_c%0d_done", i + 1), {busy, done}, 2'b10);
      @(negedge clk);
    end
    chk("trace_c5_done", done, 1'b1);
    chk("trace_c5_result", {maior, menor, igual, erro}, 4'b0100);

    // Results held across idle cycles
    run_cmp(16'hFFFF, 16'hFFFF, cyc);
    chk("hold_lat", cyc, 5);
    repeat (4) @(negedge clk);
    chk("hold_idle", {busy, done, maior, menor, igual, erro}, 6'b000010);

    // Protocol: start held high, operands change while busy
    @(negedge clk);
    a = 16'h9000;
    b = 16'h1FFF;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a = 16'h0000;
    b = 16'hFFFF;
    chk("proto_c1", {busy, done}, 2'b10);
    @(negedge clk);
    chk("proto_c2_done", {busy, done}, 2'b11);
    chk("proto_c2_result", {maior, menor, igual, erro}, 4'b1000);
    @(negedge clk);
    chk("proto_c3_idle", {busy, done}, 2'b00);
    @(negedge clk);
    chk("proto_c4_restart", {busy, done}, 2'b10);
    start = 1'b0;
    @(negedge clk);
    chk("proto_c5_done", done, 1'b1);
    chk("proto_c5_result", {maior, menor, igual, erro}, 4'b0100);
    ndone = 0;
    repeat (4) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
    end
    chk("proto_no_double_done", ndone, 0);
    chk("proto_idle", busy, 1'b0);

    // Error path: maior and igual both high
    force_en    = 1'b1;
    force_flags = 3'b101;
    run_cmp(16'h1234, 16'h5678, cyc);
    chk("err2_lat", cyc, 2);
    chk("err2_result", {maior, menor, igual, erro}, 4'b0001);
    // Error path: no flag high (preload a different result first)
    force_en = 1'b0;
    run_cmp(16'h0000, 16'h0000, cyc);
    chk("pre_err0_result", {maior, menor, igual, erro}, 4'b0010);
    force_en    = 1'b1;
    force_flags = 3'b000;
    run_cmp(16'h4444, 16'h4444, cyc);
    chk("err0_lat", cyc, 2);
    chk("err0_result", {maior, menor, igual, erro}, 4'b0001);
    force_en = 1'b0;
    @(negedge clk);

    // Reset mid-COMPARA aborts with no done afterwards
    @(negedge clk);
    a = 16'h1234;
    b = 16'h1234;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("abort_pre_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("abort_outputs", {busy, done, maior, menor, igual, erro}, 6'b000000);
    chk("abort_nib", {nib_a, nib_b}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    repeat (8) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) ndone++;
    end
    chk("abort_no_done", ndone, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/comparador_serial_nibble.md
Name: comparador_serial_nibble

Overview:
- Sequential multi-nibble magnitude comparator, one stage upstream and downstream of the 4-bit comparator.
- Latches two unsigned N_NIBBLES×4-bit operands, then drives one nibble pair per cycle into an external 4-bit comparator, MSB nibble first.
- Consumes the comparator's maior/menor/igual flags and stops at the first unequal nibble.
- Reports a registered full-width a>b / a<b / a==b result with a one-cycle done pulse.

Parameters:
- N_NIBBLES, 4, number of 4-bit nibbles per operand; operand width W = 4*N_NIBBLES; legal range 2..16.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request a comparison; sampled only in IDLE
- a  input  W  operand A, unsigned; sampled on accepted start
- b  input  W  operand B, unsigned; sampled on accepted start
- nib_a  output  4  current A nibble to comparator
- nib_b  output  4  current B nibble to comparator
- cmp_maior  input  1  comparator flag: nib_a > nib_b
- cmp_menor  input  1  comparator flag: nib_a < nib_b
- cmp_igual  input  1  comparator flag: nib_a == nib_b
- busy  output  1  high from accepted start until done
- done  output  1  one-cycle pulse when the result is valid
- maior  output  1  registered result a > b
- menor  output  1  registered result a < b
- igual  output  1  registered result a == b
- erro  output  1  registered: comparator returned a non-one-hot flag set

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; busy=0, done=0, maior=0, menor=0, igual=0, erro=0; operand registers=0; nibble index=0; nib_a=nib_b=0.
- Reset asserted mid-comparison aborts immediately. No done pulse follows.
- States: IDLE, COMPARA, FIM.
- IDLE:
  - start=1 latches a and b into a_reg and b_reg, sets idx=N_NIBBLES-1 and busy=1, then goes to COMPARA.
  - start=0 holds the state.
  - Result outputs hold their last values.
- COMPARA:
  - nib_a = a_reg[4*idx+3 : 4*idx] and nib_b = b_reg[4*idx+3 : 4*idx], combinational from registers.
  - The comparator is purely combinational; its flags are sampled on the same cycle's rising edge.
  - Flags exactly one-hot with cmp_maior=1: capture maior=1, menor=0, igual=0, erro=0; go to FIM.
  - Flags exactly one-hot with cmp_menor=1: capture maior=0, menor=1, igual=0, erro=0; go to FIM.
  - cmp_igual=1 and idx>0: idx decrements, stay in COMPARA.
  - cmp_igual=1 and idx==0: capture igual=1, maior=0, menor=0, erro=0; go to FIM.
  - Flags not one-hot (zero or more than one high): capture erro=1, maior=menor=igual=0; go to FIM.
- FIM: done=1 for exactly this cycle, busy=0 from the next cycle, state returns to IDLE.
- Result registers change only on the edge that enters FIM. They are valid from the done cycle and held until the next FIM.
- Latency: if start is accepted at edge E0 and k nibbles are examined (1..N_NIBBLES), done is high in the cycle after edge E0+k.
  - Best case (MSB nibbles differ): done 2 cycles after the start edge.
  - Worst case (equal operands, or only the LSB nibble differs): done N_NIBBLES+1 cycles after the start edge.
- start while busy or in FIM is ignored. Operands are not re-sampled, and changes to a and b during busy have no effect.
- start high on the same cycle done is high is ignored, since FIM is not IDLE. Back-to-back throughput is therefore one comparison per k+2 cycles.
- nib_a and nib_b in IDLE and FIM drive the nibble at the current idx (don't-care for the comparator). After reset, idx=0.
- All arithmetic is unsigned. No wrap-around of idx: it never decrements below 0.

Test Plan:
- Reset: assert rst_n=0 mid-COMPARA with a=16'h1234, b=16'h1234 at cycle 2 -> all outputs 0 immediately, state IDLE, no done pulse after release.
- MSB decides: N_NIBBLES=4, a=16'h9000, b=16'h1FFF, start -> nib_a=9 and nib_b=1 on cycle 1, done on cycle 2 with maior=1, menor=0, igual=0, erro=0.
- LSB decides: a=16'hABC3, b=16'hABC7 -> nibbles A/A, B/B, C/C, 3/7 driven on cycles 1–4, done on cycle 5 with menor=1.
- Equality and extremes: a=b=16'hFFFF, then a=b=16'h0000 -> done after 5 cycles with igual=1 each time; results held between runs.
- Protocol: start held high throughout and a/b changed while busy -> only the first operands are used. The next comparison starts only on a start in IDLE, after done. No double done.
- Error path: force cmp_maior=cmp_igual=1 on the first compare cycle -> done on cycle 2 with erro=1 and maior=menor=igual=0. Forcing all flags to 0 gives the same result.
